adc_clkgen_seq: RTL and testbench

// Synchronous, parametrised conversion-clock sequencer for the SAR ADC digital core. It generates the

---
 rtl/adc_clkgen_seq.sv | 190 +++++++++++++++++++
 tb/tb_adc_clkgen_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_clkgen_seq.sv
// SAR ADC conversion-clock sequencer: sample window, comparator clock and SAR clock
// phases generated from programmable delay counters, with a comparator-decision timeout.
module adc_clkgen_seq #(
    parameter int unsigned NUM_CYCLES = 12,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned TIMEOUT    = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena_in,
    input  logic             start_conv_in,
    input  logic             ndecision_finish_in,
    input  logic             enable_dlycontrol_in,
    input  logic [CNT_W-1:0] dly1_in,
    input  logic [CNT_W-1:0] dly2_in,
    input  logic [CNT_W-1:0] dly3_in,
    input  logic [CNT_W-1:0] dly4_in,
    output logic             sample_out,
    output logic             nsample_out,
    output logic             clk_comp_out,
    output logic             clk_dig_out,
    output logic             busy_out,
    output logic             conv_done_out,
    output logic             timeout_out
);
    localparam int unsigned BIT_W = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CW    = (CNT_W > TO_W) ? CNT_W : TO_W;

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_DLY1, S_COMP, S_DLY2, S_DIG, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
    logic             start_s1_q, start_s2_q, start_dl_q;
    logic             ndec_s1_q, ndec_s2_q;
    logic             start_edge, phase_last, tmo_hit;
    logic [CNT_W-1:0] phase_len;
    logic             sample_d, clk_comp_d, clk_dig_d, busy_d, conv_done_d, timeout_d;

    // Zero programs a one-cycle phase; delay control off forces the longest phase.
    function automatic logic [CNT_W-1:0] eff_dly(input logic ctl, input logic [CNT_W-1:0] d);
        if (!ctl) return '1;
        if (d == '0) return CNT_W'(1);
        return d;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_dl_q <= 1'b0;
            ndec_s1_q  <= 1'b1;
            ndec_s2_q  <= 1'b1;
        end else begin
            start_s1_q <= start_conv_in;
            start_s2_q <= start_s1_q;
            start_dl_q <= start_s2_q;
            ndec_s1_q  <= ndecision_finish_in;
            ndec_s2_q  <= ndec_s1_q;
        end
    end

    assign start_edge = start_s2_q & ~start_dl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            d4_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            d4_q    <= d4_d;
        end
    end

    always_comb begin
        case (state_q)
            S_SAMPLE: phase_len = d4_q;
            S_DLY2:   phase_len = d2_q;
            S_DIG:    phase_len = d3_q;
            default:  phase_len = d1_q;
        endcase
        phase_last = (cnt_q == (CW'(phase_len) - CW'(1)));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        d4_d    = d4_q;
        tmo_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_edge && ena_in) begin
                    state_d = S_SAMPLE;
                    bit_d   = '0;
                    d1_d    = eff_dly(enable_dlycontrol_in, dly1_in);
                    d2_d    = eff_dly(enable_dlycontrol_in, dly2_in);
                    d3_d    = eff_dly(enable_dlycontrol_in, dly3_in);
                    d4_d    = eff_dly(enable_dlycontrol_in, dly4_in);
                end
            end
            S_SAMPLE: if (phase_last) begin state_d = S_DLY1; cnt_d = '0; end
            S_DLY1:   if (phase_last) begin state_d = S_COMP; cnt_d = '0; end
            S_COMP: begin
                // First two COMP cycles ignore the (possibly stale) decision input.
                if (cnt_q >= CW'(2) && !ndec_s2_q) begin
                    state_d = S_DLY2;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_DLY2;
                    cnt_d   = '0;
                    tmo_hit = 1'b1;
                end
            end
            S_DLY2:   if (phase_last) begin state_d = S_DIG; cnt_d = '0; end
            S_DIG: begin
                if (phase_last) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(NUM_CYCLES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DLY1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!ena_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tmo_hit = 1'b0;
        end
    end

    always_comb begin
        sample_d    = (state_d == S_SAMPLE);
        clk_comp_d  = (state_d == S_COMP);
        clk_dig_d   = (state_d == S_DIG);
        busy_d      = (state_d != S_IDLE);
        conv_done_d = (state_d == S_DONE);
        timeout_d   = tmo_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out    <= 1'b0;
            nsample_out   <= 1'b1;
            clk_comp_out  <= 1'b0;
            clk_dig_out   <= 1'b0;
            busy_out      <= 1'b0;
            conv_done_out <= 1'b0;
            timeout_out   <= 1'b0;
        end else begin
            sample_out    <= sample_d;
            nsample_out   <= ~sample_d;
            clk_comp_out  <= clk_comp_d;
            clk_dig_out   <= clk_dig_d;
            busy_out      <= busy_d;
            conv_done_out <= conv_done_d;
            timeout_out   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_adc_clkgen_seq.sv
// Bench for adc_clkgen_seq: phase run-lengths of each conversion are compared against
// a phase-list model built from the programmed delays and comparator response time.
module tb_adc_clkgen_seq;
    localparam int unsigned NUM_CYCLES = 12;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned TIMEOUT    = 63;
    localparam int BUDGET = 8000;
    localparam logic [6:0] RST_VAL = 7'b0100000;

    typedef struct {
        logic ctl;
        int   d1, d2, d3, d4;
        int   resp;
        int   exp_busy;
        int   exp_to;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, ena = 1'b0, start = 1'b0, ndec = 1'b1, ctl = 1'b1;
    logic [CNT_W-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic sample_o, nsample_o, comp_o, dig_o, busy_o, done_o, to_o;
    int total = 0, bad = 0;
    int resp_g = 1, comp_cnt = 0;
    byte exp_c[$], obs_c[$];
    int  exp_l[$], obs_l[$];
    vec_t vt[7];

    always #5 clk = ~clk;

    adc_clkgen_seq #(.NUM_CYCLES(NUM_CYCLES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ena_in(ena), .start_conv_in(start),
        .ndecision_finish_in(ndec), .enable_dlycontrol_in(ctl),
        .dly1_in(d1), .dly2_in(d2), .dly3_in(d3), .dly4_in(d4),
        .sample_out(sample_o), .nsample_out(nsample_o), .clk_comp_out(comp_o),
        .clk_dig_out(dig_o), .busy_out(busy_o), .conv_done_out(done_o), .timeout_out(to_o)
    );

    // Comparator: decides resp_g observed cycles after its clock rises (0 = never decides).
    always @(negedge clk) begin
        if (comp_o) begin
            comp_cnt = comp_cnt + 1;
            if (resp_g != 0 && comp_cnt >= resp_g) ndec = 1'b0;
        end else begin
            comp_cnt = 0;
            ndec = 1'b1;
        end
    end

    function automatic logic [6:0] outs();
        return {sample_o, nsample_o, comp_o, dig_o, busy_o, done_o, to_o};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int eff(input logic c, input int a);
        if (!c) return (2 ** CNT_W) - 1;
        return (a == 0) ? 1 : a;
    endfunction

    task automatic push_exp(input byte c, input int l);
        exp_c.push_back(c);
        exp_l.push_back(l);
    endtask

    // Expected phase list: two idle cycles of start latency, then sample, per-bit phases, done.
    task automatic build_exp(input logic c, input int a1, input int a2, input int a3, input int a4,
                             input int resp, output int busy_n, output int to_n);
        bit tmo;
        int tc;
        tmo = (resp == 0) || (resp + 2 > int'(TIMEOUT));
        tc  = tmo ? int'(TIMEOUT) : resp + 2;
        exp_c.delete();
        exp_l.delete();
        push_exp("I", 2);
        push_exp("S", eff(c, a4));
        for (int b = 0; b < int'(NUM_CYCLES); b++) begin
            push_exp("L", eff(c, a1));
            push_exp("C", tc);
            push_exp("L", eff(c, a2));
            push_exp("G", eff(c, a3));
        end
        push_exp("D", 1);
        busy_n = eff(c, a4) + int'(NUM_CYCLES) * (eff(c, a1) + tc + eff(c, a2) + eff(c, a3)) + 1;
        to_n   = tmo ? int'(NUM_CYCLES) : 0;
    endtask

    task automatic run_conv(input string tag, input int retrig, output int busy_n,
                            output int to_n, output int done_n, output int inv_n);
        byte code;
        bit seen, fin;
        seen = 0; fin = 0;
        busy_n = 0; to_n = 0; done_n = 0; inv_n = 0;
        obs_c.delete();
        obs_l.delete();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < BUDGET && !fin; i++) begin
            @(negedge clk);
            if (nsample_o == sample_o || (comp_o && dig_o) || (sample_o && (comp_o || dig_o)))
                inv_n++;
            if (to_o) to_n++;
            if (done_o) done_n++;
            if (!busy_o)       code = "I";
            else if (sample_o) code = "S";
            else if (comp_o)   code = "C";
            else if (dig_o)    code = "G";
            else if (done_o)   code = "D";
            else               code = "L";
            if (busy_o) busy_n++;
            if (obs_c.size() > 0 && obs_c[obs_c.size()-1] == code) begin
                obs_l[obs_l.size()-1] = obs_l[obs_l.size()-1] + 1;
            end else begin
                obs_c.push_back(code);
                obs_l.push_back(1);
            end
            if (busy_o) seen = 1;
            else if (seen) fin = 1;
            if (i == retrig) start = 1'b0;
            if (i == retrig + 4) start = 1'b1;
        end
        check({tag, " finished"}, int'(fin), 1);
        if (fin) begin
            void'(obs_c.pop_back());
            void'(obs_l.pop_back());
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cmp_rle(input string tag);
        int idx;
        idx = -1;
        total++;
        for (int k = 0; k < exp_c.size(); k++)
            if (idx < 0 && (k >= obs_c.size() || obs_c[k] != exp_c[k] || obs_l[k] != exp_l[k]))
                idx = k;
        if (idx < 0 && obs_c.size() != exp_c.size()) idx = exp_c.size();
        if (idx >= 0) begin
            bad++;
            if (idx < obs_c.size() && idx < exp_c.size())
                $display("FAIL %s phase %0d: got %c x%0d expected %c x%0d", tag, idx,
                         obs_c[idx], obs_l[idx], exp_c[idx], exp_l[idx]);
            else
                $display("FAIL %s phase count: got %0d expected %0d", tag, obs_c.size(), exp_c.size());
        end
    endtask

    task automatic check_conv(input string tag, input int busy_n, input int to_n, input int done_n,
                              input int inv_n, input int exp_busy, input int exp_to);
        int g;
        g = 0;
        foreach (obs_c[k]) if (obs_c[k] == "G") g++;
        check({tag, " busy_len"}, busy_n, exp_busy);
        check({tag, " timeouts"}, to_n, exp_to);
        check({tag, " conv_done"}, done_n, 1);
        check({tag, " dig_pulses"}, g, int'(NUM_CYCLES));
        check({tag, " overlap"}, inv_n, 0);
        cmp_rle(tag);
    endtask

    task automatic set_cfg(input vec_t v);
        ctl = v.ctl;
        d1 = CNT_W'(v.d1); d2 = CNT_W'(v.d2); d3 = CNT_W'(v.d3); d4 = CNT_W'(v.d4);
        resp_g = v.resp;
    endtask

    initial begin
        int bn, tn, dn, iv, mb, mt, cnt, nrise;
        bit hit, prev;
        string tag;
        vt[0] = '{1'b1, 2, 2, 2, 3, 1, 112, 0};
        vt[1] = '{1'b0, 5, 1, 0, 7, 0, 3088, 12};
        vt[2] = '{1'b1, 0, 0, 0, 0, 1, 74, 0};
        vt[3] = '{1'b1, 2, 2, 2, 3, 0, 832, 12};
        vt[4] = '{1'b1, 1, 1, 1, 1, 61, 794, 0};
        vt[5] = '{1'b1, 1, 1, 1, 1, 62, 794, 12};
        vt[6] = '{1'b1, 3, 1, 4, 5, 5, 186, 0};

        repeat (3) @(negedge clk);
        check("reset outs", int'(outs()), int'(RST_VAL));
        rst = 1'b0;
        ena = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            tag = $sformatf("vec%0d", v);
            set_cfg(vt[v]);
            run_conv(tag, -1, bn, tn, dn, iv);
            build_exp(vt[v].ctl, vt[v].d1, vt[v].d2, vt[v].d3, vt[v].d4, vt[v].resp, mb, mt);
            check_conv(tag, bn, tn, dn, iv, vt[v].exp_busy, vt[v].exp_to);
        end

        // Re-trigger during bit 5 is ignored; a later start in IDLE runs normally.
        set_cfg(vt[0]);
        run_conv("retrig", 42, bn, tn, dn, iv);
        build_exp(vt[0].ctl, vt[0].d1, vt[0].d2, vt[0].d3, vt[0].d4, vt[0].resp, mb, mt);
        check_conv("retrig", bn, tn, dn, iv, vt[0].exp_busy, vt[0].exp_to);
        check("retrig idle after", int'(outs()), int'(RST_VAL));
        run_conv("after_retrig", -1, bn, tn, dn, iv);
        check_conv("after_retrig", bn, tn, dn, iv, vt[0].exp_busy, vt[0].exp_to);

        // Enable dropped at the start of the 7th COMP phase.
        @(negedge clk);
        start = 1'b1;
        nrise = 0; prev = 0;
        for (int i = 0; i < BUDGET && nrise < 7; i++) begin
            @(negedge clk);
            if (comp_o && !prev) nrise++;
            prev = comp_o;
        end
        check("abort reached comp7", nrise, 7);
        ena = 1'b0;
        @(negedge clk);
        check("abort outs", int'(outs()), int'(RST_VAL));
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (outs() != RST_VAL) cnt++;
        end
        check("abort quiet", cnt, 0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_o) cnt++;
        end
        check("start while disabled", cnt, 0);
        ena = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_o) cnt++;
        end
        check("no queued start", cnt, 0);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset while the SAR clock is high.
        set_cfg(vt[0]);
        @(negedge clk);
        start = 1'b1;
        hit = 0;
        for (int i = 0; i < BUDGET && !hit; i++) begin
            @(negedge clk);
            if (dig_o) hit = 1;
        end
        check("rst reached dig", int'(hit), 1);
        #2 rst = 1'b1;
        #1;
        check("rst dig immediate", int'(dig_o), 0);
        check("rst outs immediate", int'(outs()), int'(RST_VAL));
        start = 1'b0;
        #1 rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (outs() != RST_VAL) cnt++;
        end
        check("post rst quiet", cnt, 0);
        run_conv("post_rst", -1, bn, tn, dn, iv);
        check_conv("post_rst", bn, tn, dn, iv, vt[0].exp_busy, vt[0].exp_to);

        for (int r = 0; r < 8; r++) begin
            vec_t rv;
            rv.ctl = ($urandom_range(0, 5) != 0);
            rv.d1 = int'($urandom_range(0, 4));
            rv.d2 = int'($urandom_range(0, 4));
            rv.d3 = int'($urandom_range(0, 4));
            rv.d4 = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 6));
            rv.resp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(58, 66))
                                                 : int'($urandom_range(0, 6));
            build_exp(rv.ctl, rv.d1, rv.d2, rv.d3, rv.d4, rv.resp, mb, mt);
            rv.exp_busy = mb;
            rv.exp_to = mt;
            tag = $sformatf("rand%0d", r);
            set_cfg(rv);
            run_conv(tag, -1, bn, tn, dn, iv);
            check_conv(tag, bn, tn, dn, iv, rv.exp_busy, rv.exp_to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
